// File: rtl/reservation_station_multi.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_multi
// Purpose  : ALU reservation station with DEPTH entries, NUM_CDB snooped
//            broadcast channels, oldest-first issue and a free-slot count.
//            Dispatch writes the lowest free entry, operands are woken from
//            any CDB channel (also in the dispatch cycle), and clear flushes.
// Ports    : clk_in/rst_in (async high)  clock / reset
//            rdy_in                      global ready, low freezes all state
//            clear / stall               flush / inhibit issue
//            disp_*                      dispatch request and payload
//            rs_full / free_cnt          occupancy status
//            cdb_valid/rob_id/value      packed broadcast channels
//            alu_full                    ALU back-pressure
//            alu_ready / alu_*           issue pulse and payload
// Revision : 1.0  initial release
// ============================================================================
module reservation_station_multi #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 5,
    parameter int XLEN    = 32,
    parameter int TYPE_W  = 5,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     stall,
    input  logic                     disp_valid,
    input  logic [TYPE_W-1:0]        disp_type,
    input  logic [ROB_W-1:0]         disp_rob_id,
    input  logic [XLEN-1:0]          disp_v1,
    input  logic [XLEN-1:0]          disp_v2,
    input  logic [XLEN-1:0]          disp_imm,
    input  logic                     disp_has_dep1,
    input  logic                     disp_has_dep2,
    input  logic [ROB_W-1:0]         disp_dep1,
    input  logic [ROB_W-1:0]         disp_dep2,
    output logic                     rs_full,
    output logic [$clog2(DEPTH):0]   free_cnt,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    input  logic                     alu_full,
    output logic                     alu_ready,
    output logic [TYPE_W-1:0]        alu_type,
    output logic [ROB_W-1:0]         alu_rob_id,
    output logic [XLEN-1:0]          alu_op1,
    output logic [XLEN-1:0]          alu_op2,
    output logic [XLEN-1:0]          alu_imm
);

    localparam int                 AGE_W     = $clog2(DEPTH);
    localparam int                 CNT_W     = AGE_W + 1;
    localparam logic [AGE_W-1:0]   C_AGE_MAX = AGE_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   C_DEPTH   = CNT_W'(DEPTH);

    logic              r_valid [DEPTH];
    logic [TYPE_W-1:0] r_type  [DEPTH];
    logic [ROB_W-1:0]  r_rob   [DEPTH];
    logic [XLEN-1:0]   r_v1    [DEPTH];
    logic [XLEN-1:0]   r_v2    [DEPTH];
    logic [XLEN-1:0]   r_imm   [DEPTH];
    logic              r_pend1 [DEPTH];
    logic              r_pend2 [DEPTH];
    logic [ROB_W-1:0]  r_dep1  [DEPTH];
    logic [ROB_W-1:0]  r_dep2  [DEPTH];
    logic [AGE_W-1:0]  r_age   [DEPTH];
    logic [CNT_W-1:0]  r_count;

    // {hit, value}: the lowest-numbered channel matching the tag wins, so
    // channels are scanned from the top down and the last hit sticks.
    function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, cdb_value[k*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    logic [XLEN:0]    w_wk1 [DEPTH];
    logic [XLEN:0]    w_wk2 [DEPTH];
    logic [XLEN:0]    w_byp1;
    logic [XLEN:0]    w_byp2;
    logic             w_any_ready;
    logic [AGE_W-1:0] w_sel;
    logic [AGE_W-1:0] w_sel_age;
    logic [AGE_W-1:0] w_free;
    logic             w_free_found;
    logic             w_accept;
    logic             w_issue;

    assign rs_full  = (r_count == C_DEPTH);
    assign free_cnt = C_DEPTH - r_count;

    always_comb begin
        w_byp1 = cdb_lookup(disp_dep1);
        w_byp2 = cdb_lookup(disp_dep2);
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i] = cdb_lookup(r_dep1[i]);
            w_wk2[i] = cdb_lookup(r_dep2[i]);
        end
    end

    // Oldest ready entry; strict '>' keeps the lowest index on age ties.
    always_comb begin
        w_any_ready = 1'b0;
        w_sel       = '0;
        w_sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_pend1[i] && !r_pend2[i] &&
                (!w_any_ready || (r_age[i] > w_sel_age))) begin
                w_any_ready = 1'b1;
                w_sel       = AGE_W'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free       = AGE_W'(i);
            end
        end
    end

    // rdy_in gating is applied by the enclosing branch of the state update.
    assign w_accept = disp_valid && !rs_full && !clear;
    assign w_issue  = w_any_ready && !clear && !stall && !alu_full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_type[i]  <= '0;
                r_rob[i]   <= '0;
                r_v1[i]    <= '0;
                r_v2[i]    <= '0;
                r_imm[i]   <= '0;
                r_pend1[i] <= 1'b0;
                r_pend2[i] <= 1'b0;
                r_dep1[i]  <= '0;
                r_dep2[i]  <= '0;
                r_age[i]   <= '0;
            end
            r_count    <= '0;
            alu_ready  <= 1'b0;
            alu_type   <= '0;
            alu_rob_id <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_imm    <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_valid[i] <= 1'b0;
                end
                r_count   <= '0;
                alu_ready <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i]) begin
                        if (r_pend1[i] && w_wk1[i][XLEN]) begin
                            r_v1[i]    <= w_wk1[i][XLEN-1:0];
                            r_pend1[i] <= 1'b0;
                        end
                        if (r_pend2[i] && w_wk2[i][XLEN]) begin
                            r_v2[i]    <= w_wk2[i][XLEN-1:0];
                            r_pend2[i] <= 1'b0;
                        end
                        if (w_accept && (r_age[i] != C_AGE_MAX)) begin
                            r_age[i] <= r_age[i] + AGE_W'(1);
                        end
                    end
                end

                if (w_issue) begin
                    alu_ready      <= 1'b1;
                    alu_type       <= r_type[w_sel];
                    alu_rob_id     <= r_rob[w_sel];
                    alu_op1        <= r_v1[w_sel];
                    alu_op2        <= r_v2[w_sel];
                    alu_imm        <= r_imm[w_sel];
                    r_valid[w_sel] <= 1'b0;
                end else begin
                    alu_ready <= 1'b0;
                end

                // The free slot is invalid, so it never collides with the
                // wakeup/aging updates above or with the issued entry.
                if (w_accept) begin
                    r_valid[w_free] <= 1'b1;
                    r_type[w_free]  <= disp_type;
                    r_rob[w_free]   <= disp_rob_id;
                    r_imm[w_free]   <= disp_imm;
                    r_dep1[w_free]  <= disp_dep1;
                    r_dep2[w_free]  <= disp_dep2;
                    r_age[w_free]   <= '0;
                    r_v1[w_free]    <= (disp_has_dep1 && w_byp1[XLEN]) ? w_byp1[XLEN-1:0] : disp_v1;
                    r_v2[w_free]    <= (disp_has_dep2 && w_byp2[XLEN]) ? w_byp2[XLEN-1:0] : disp_v2;
                    r_pend1[w_free] <= disp_has_dep1 && !w_byp1[XLEN];
                    r_pend2[w_free] <= disp_has_dep2 && !w_byp2[XLEN];
                end

                r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station_multi
// Purpose  : Self-checking bench for reservation_station_multi. Directed
//            scenarios followed by random traffic, all compared against a
//            slot-array model whose ages come from dispatch sequence numbers.
// Revision : 1.0  initial release
// ============================================================================
module tb_reservation_station_multi;

    localparam int D  = 8;
    localparam int RW = 5;
    localparam int XL = 32;
    localparam int TW = 5;
    localparam int NC = 2;

    logic             clk = 1'b0;
    logic             rst_in = 1'b1;
    logic             rdy_in = 1'b1;
    logic             clear = 1'b0;
    logic             stall = 1'b0;
    logic             disp_valid = 1'b0;
    logic [TW-1:0]    disp_type = '0;
    logic [RW-1:0]    disp_rob_id = '0;
    logic [XL-1:0]    disp_v1 = '0;
    logic [XL-1:0]    disp_v2 = '0;
    logic [XL-1:0]    disp_imm = '0;
    logic             disp_has_dep1 = 1'b0;
    logic             disp_has_dep2 = 1'b0;
    logic [RW-1:0]    disp_dep1 = '0;
    logic [RW-1:0]    disp_dep2 = '0;
    logic [NC-1:0]    cdb_valid = '0;
    logic [NC*RW-1:0] cdb_rob_id = '0;
    logic [NC*XL-1:0] cdb_value = '0;
    logic             alu_full = 1'b0;
    logic             rs_full;
    logic [3:0]       free_cnt;
    logic             alu_ready;
    logic [TW-1:0]    alu_type;
    logic [RW-1:0]    alu_rob_id;
    logic [XL-1:0]    alu_op1;
    logic [XL-1:0]    alu_op2;
    logic [XL-1:0]    alu_imm;

    always #5 clk = ~clk;

    reservation_station_multi #(
        .DEPTH(D), .ROB_W(RW), .XLEN(XL), .TYPE_W(TW), .NUM_CDB(NC)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .stall(stall),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_imm(disp_imm),
        .disp_has_dep1(disp_has_dep1), .disp_has_dep2(disp_has_dep2),
        .disp_dep1(disp_dep1), .disp_dep2(disp_dep2),
        .rs_full(rs_full), .free_cnt(free_cnt),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .alu_full(alu_full), .alu_ready(alu_ready), .alu_type(alu_type),
        .alu_rob_id(alu_rob_id), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm)
    );

    // ---------------- reference model ----------------
    bit            m_valid [D];
    logic [TW-1:0] m_type  [D];
    logic [RW-1:0] m_rob   [D];
    logic [XL-1:0] m_v1    [D];
    logic [XL-1:0] m_v2    [D];
    logic [XL-1:0] m_imm   [D];
    bit            m_p1    [D];
    bit            m_p2    [D];
    logic [RW-1:0] m_d1    [D];
    logic [RW-1:0] m_d2    [D];
    int            m_seq   [D];
    int            m_total;
    logic          e_ready;
    logic [TW-1:0] e_type;
    logic [RW-1:0] e_rob;
    logic [XL-1:0] e_op1, e_op2, e_imm;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
        end
        m_total = 0;
        e_ready = 0; e_type = '0; e_rob = '0; e_op1 = '0; e_op2 = '0; e_imm = '0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < D; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    // Age = number of later accepted dispatches, capped at D-1.
    function automatic int age_of(int i);
        int a = m_total - m_seq[i] - 1;
        return (a > D - 1) ? D - 1 : a;
    endfunction

    task automatic cdb_find(input logic [RW-1:0] tag, output bit hit, output logic [XL-1:0] val);
        hit = 0; val = '0;
        for (int k = 0; k < NC; k++) begin
            if (!hit && cdb_valid[k] && cdb_rob_id[k*RW +: RW] == tag) begin
                hit = 1; val = cdb_value[k*XL +: XL];
            end
        end
    endtask

    task automatic model_edge();
        int best, free_slot, cnt;
        bit hit, issue, accept;
        logic [XL-1:0] val;
        if (!rdy_in) return;
        if (clear) begin
            for (int i = 0; i < D; i++) m_valid[i] = 0;
            e_ready = 0;
            return;
        end
        cnt = model_count();
        best = -1;
        for (int i = 0; i < D; i++)
            if (m_valid[i] && !m_p1[i] && !m_p2[i] && (best < 0 || age_of(i) > age_of(best)))
                best = i;
        free_slot = -1;
        for (int i = D - 1; i >= 0; i--) if (!m_valid[i]) free_slot = i;
        issue  = !stall && !alu_full && best >= 0;
        accept = disp_valid && cnt < D;
        for (int i = 0; i < D; i++) begin
            if (m_valid[i] && m_p1[i]) begin
                cdb_find(m_d1[i], hit, val);
                if (hit) begin m_v1[i] = val; m_p1[i] = 0; end
            end
            if (m_valid[i] && m_p2[i]) begin
                cdb_find(m_d2[i], hit, val);
                if (hit) begin m_v2[i] = val; m_p2[i] = 0; end
            end
        end
        if (issue) begin
            e_ready = 1; e_type = m_type[best]; e_rob = m_rob[best];
            e_op1 = m_v1[best]; e_op2 = m_v2[best]; e_imm = m_imm[best];
            m_valid[best] = 0;
        end else begin
            e_ready = 0;
        end
        if (accept) begin
            m_valid[free_slot] = 1;
            m_type[free_slot]  = disp_type;
            m_rob[free_slot]   = disp_rob_id;
            m_imm[free_slot]   = disp_imm;
            m_d1[free_slot]    = disp_dep1;
            m_d2[free_slot]    = disp_dep2;
            m_v1[free_slot]    = disp_v1;
            m_v2[free_slot]    = disp_v2;
            m_p1[free_slot]    = 0;
            m_p2[free_slot]    = 0;
            if (disp_has_dep1) begin
                cdb_find(disp_dep1, hit, val);
                if (hit) m_v1[free_slot] = val; else m_p1[free_slot] = 1;
            end
            if (disp_has_dep2) begin
                cdb_find(disp_dep2, hit, val);
                if (hit) m_v2[free_slot] = val; else m_p2[free_slot] = 1;
            end
            m_seq[free_slot] = m_total;
            m_total++;
        end
    endtask

    task automatic check_outputs(input string tag);
        int cnt = model_count();
        chk({tag, ".alu_ready"},  64'(alu_ready),  64'(e_ready));
        chk({tag, ".alu_rob_id"}, 64'(alu_rob_id), 64'(e_rob));
        chk({tag, ".alu_type"},   64'(alu_type),   64'(e_type));
        chk({tag, ".alu_op1"},    64'(alu_op1),    64'(e_op1));
        chk({tag, ".alu_op2"},    64'(alu_op2),    64'(e_op2));
        chk({tag, ".alu_imm"},    64'(alu_imm),    64'(e_imm));
        chk({tag, ".free_cnt"},   64'(free_cnt),   64'(D - cnt));
        chk({tag, ".rs_full"},    64'(rs_full),    64'(cnt == D));
    endtask

    // Inputs are stable here; the model commits the edge, then outputs are
    // sampled 1 ns after the DUT edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        rdy_in = 1; clear = 0; stall = 0; alu_full = 0;
        disp_valid = 0; disp_has_dep1 = 0; disp_has_dep2 = 0;
        cdb_valid = '0;
    endtask

    task automatic set_disp(input int rob, input int v1, input int v2,
                            input bit h1, input int d1, input bit h2, input int d2);
        disp_valid    = 1;
        disp_rob_id   = RW'(rob);
        disp_v1       = XL'(v1);
        disp_v2       = XL'(v2);
        disp_imm      = XL'($urandom);
        disp_type     = TW'($urandom_range(0, 31));
        disp_has_dep1 = h1;
        disp_dep1     = RW'(d1);
        disp_has_dep2 = h2;
        disp_dep2     = RW'(d2);
    endtask

    task automatic set_cdb(input int k, input int tag, input int val);
        cdb_valid[k]            = 1'b1;
        cdb_rob_id[k*RW +: RW]  = RW'(tag);
        cdb_value[k*XL +: XL]   = XL'(val);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        rst_in = 0;

        // Plain dispatch, issued one cycle after it becomes ready.
        idle(); set_disp(3, 5, 7, 0, 0, 0, 0);
        step("t1_disp");
        idle();
        step("t1_issue");
        chk("t1_rob", 64'(alu_rob_id), 64'd3);
        chk("t1_op1", 64'(alu_op1), 64'd5);
        chk("t1_op2", 64'(alu_op2), 64'd7);
        chk("t1_free", 64'(free_cnt), 64'd8);

        // Pending dep1 woken by channel 1 two cycles later.
        idle(); set_disp(4, 1, 2, 1, 2, 0, 0);
        step("t2_disp");
        idle();
        step("t2_wait");
        set_cdb(1, 2, 32'h55);
        step("t2_wake");
        idle();
        step("t2_issue");
        chk("t2_ready", 64'(alu_ready), 64'd1);
        chk("t2_op1", 64'(alu_op1), 64'h55);

        // Dispatch bypass on channel 0.
        idle(); set_disp(6, 1, 2, 0, 0, 1, 9); set_cdb(0, 9, 32'hAB);
        step("t3_disp");
        idle();
        step("t3_issue");
        chk("t3_rob", 64'(alu_rob_id), 64'd6);
        chk("t3_op2", 64'(alu_op2), 64'hAB);

        // Fill with ALU blocked, ninth dispatch ignored, then oldest first.
        for (int n = 0; n < 9; n++) begin
            idle(); alu_full = 1;
            set_disp(10 + n, n, n + 100, 0, 0, 0, 0);
            step("t4_fill");
        end
        chk("t4_full", 64'(rs_full), 64'd1);
        chk("t4_free0", 64'(free_cnt), 64'd0);
        idle();
        step("t4_drain");
        chk("t4_oldest", 64'(alu_rob_id), 64'd10);
        chk("t4_notfull", 64'(rs_full), 64'd0);
        for (int n = 0; n < 3; n++) step("t4_drain_more");

        // Clear with dispatch and CDB match in the same cycle.
        idle(); set_disp(20, 1, 1, 1, 7, 0, 0); set_cdb(0, 7, 1); clear = 1;
        step("t5_clear");
        chk("t5_free", 64'(free_cnt), 64'd8);
        chk("t5_ready", 64'(alu_ready), 64'd0);
        idle();
        step("t5_after");
        step("t5_after");

        // Freeze with ready entries and CDB activity.
        for (int n = 0; n < 2; n++) begin
            idle(); alu_full = 1; set_disp(21 + n, n, n, 0, 0, 1, 12);
            step("t6_fill");
        end
        idle(); rdy_in = 0; set_cdb(0, 12, 32'h77);
        for (int n = 0; n < 3; n++) step("t6_frozen");
        chk("t6_hold_free", 64'(free_cnt), 64'd6);
        idle(); set_cdb(1, 12, 32'h99);
        step("t6_resume_wake");
        idle();
        step("t6_resume_issue");
        chk("t6_op2", 64'(alu_op2), 64'h99);
        chk("t6_rob", 64'(alu_rob_id), 64'd21);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            idle();
            rdy_in   = ($urandom_range(0, 15) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            alu_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                set_disp($urandom_range(0, 31), $urandom, $urandom,
                         $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                         $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            for (int k = 0; k < NC; k++)
                if ($urandom_range(0, 1) == 1) set_cdb(k, $urandom_range(0, 15), $urandom);
            step("rand");
        end

        // Asynchronous reset between edges.
        idle(); alu_full = 1; set_disp(30, 1, 2, 0, 0, 0, 0);
        step("t7_disp");
        idle(); set_disp(31, 3, 4, 0, 0, 0, 0);
        step("t7_issue");
        #2;
        rst_in = 1;
        #1;
        model_reset();
        check_outputs("t7_async");
        chk("t7_op1_zero", 64'(alu_op1), 64'd0);
        #2;
        rst_in = 0;
        idle();
        step("t7_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reservation_station_multi.md
Name: reservation_station_multi

Overview:
- Parametrised successor to the single-CDB ALU reservation station: DEPTH entries, NUM_CDB snooped broadcast channels, oldest-first issue, free-slot count.
- Sits between the instruction fetcher/dispatcher (allocation) and the ALU (issue).
- Wakes operands from any CDB channel, including in the same cycle as dispatch.
- Flushes completely on clear.

Parameters:
- DEPTH, 8, number of entries (power of 2, >=2)
- ROB_W, 5, ROB tag width
- XLEN, 32, operand/data width
- TYPE_W, 5, op-type width
- NUM_CDB, 2, number of CDB broadcast channels (ALU, LSB, ...)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global ready; low freezes all state
- clear  in  1  synchronous flush (mispredict)
- stall  in  1  inhibits issue only
- disp_valid  in  1  dispatch request
- disp_type  in  TYPE_W  op type
- disp_rob_id  in  ROB_W  destination ROB tag
- disp_v1, disp_v2, disp_imm  in  XLEN each  operand values / immediate
- disp_has_dep1, disp_has_dep2  in  1 each  operand pending
- disp_dep1, disp_dep2  in  ROB_W each  producer tags
- rs_full  out  1  no free entry (combinational from count)
- free_cnt  out  $clog2(DEPTH)+1  free entries
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_W  packed tags, channel k at [k*ROB_W +: ROB_W]
- cdb_value  in  NUM_CDB*XLEN  packed values
- alu_full  in  1  ALU cannot accept
- alu_ready  out  1  issue pulse
- alu_type  out  TYPE_W
- alu_rob_id  out  ROB_W
- alu_op1, alu_op2, alu_imm  out  XLEN each

Behaviour:
- Reset (async, rst_in=1): all entries invalid, ages 0, count 0; alu_ready=0, alu_* data=0; rs_full=0, free_cnt=DEPTH.
- rdy_in=0: no state changes; outputs hold.
- clear=1 (rdy_in=1): at the next edge all entries invalid, count 0, alu_ready=0. Overrides dispatch, issue and wakeup in that cycle.
- Entry fields: valid, type, rob_id, v1, v2, imm, dep1/dep2 pending flags + tags, age.
- Dispatch accept = disp_valid & !rs_full & rdy_in & !clear.
  - Writes the lowest-index free entry at the edge, age 0.
  - All other valid entries increment age, saturating at DEPTH-1.
  - disp_valid while rs_full: ignored, no state change. Dispatcher must hold.
- Wakeup: for every valid entry with a pending dep whose tag equals cdb_rob_id[k] with cdb_valid[k]:
  - value captured into v1/v2 and pending flag cleared at the edge.
  - Multiple matching channels: lowest k wins.
- Dispatch bypass: if disp_dep1/2 matches an active CDB channel in the accept cycle, the entry is written already resolved with that CDB value.
- Ready entry: valid with no pending deps in registered state. Entries woken or dispatched this cycle become eligible next cycle (min dispatch-to-issue latency 1 cycle).
- Issue enable = rdy_in & !clear & !stall & !alu_full & (any ready entry).
  - Selects ready entry with largest age; ties -> lowest index.
  - At the edge: alu_ready=1, alu_* loaded from that entry, entry freed.
  - Otherwise alu_ready=0 next cycle and alu_* data hold.
  - At most one issue per cycle; alu_ready is a single-cycle pulse per instruction.
- Count: count_next = count + accept - issue; same-cycle accept and issue when full is impossible (rs_full blocks accept).
  - Issue when full frees a slot; rs_full deasserts the following cycle.
- rs_full = (count==DEPTH); free_cnt = DEPTH - count.
- Wrap/boundary: age saturates, never wraps; ROB tag compare is exact equality, no wrap semantics.
- Reset asserted mid-operation: immediate return to reset state regardless of clock.

Test Plan:
- Dispatch rob 3, no deps, v1=5, v2=7 -> next cycle entry ready; cycle after, alu_ready=1, rob_id=3, op1=5, op2=7; free_cnt back to 8.
- Dispatch rob 4 with dep1=2 pending; CDB ch1 broadcasts tag 2 value 0x55 two cycles later -> issue one cycle after broadcast with op1=0x55.
- Dispatch rob 6 with dep2=9 while CDB ch0 broadcasts 9/0xAB same cycle -> entry resolved at write, issues with op2=0xAB.
- Fill 8 entries with alu_full=1 -> rs_full=1, free_cnt=0, 9th dispatch ignored; release alu_full -> oldest (first dispatched) issues first, rs_full drops next cycle.
- With 4 valid entries, assert clear alongside a dispatch and a CDB match -> all invalid, free_cnt=8, alu_ready=0, nothing issues afterward.
- rdy_in=0 for 3 cycles with ready entries and CDB activity -> no issue, no state change; resumes identically on rdy_in=1. Async rst_in mid-cycle -> outputs zero immediately.
